// File: rtl/dcpu_bus_pkg.sv
// Shared encodings for the dcpu memory bus: arbiter states, port indices and
// read/write strobe polarity.
package dcpu_bus_pkg;

  typedef enum logic {
    S_ARB  = 1'b0,
    S_LOCK = 1'b1
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/dcpu_arb_starve_ctr.sv
// Saturating count of consecutive cycles the DMA port was denied; hit flags
// that the limit is reached and DMA must be promoted.
module dcpu_arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [3:0] Limit = 4'(LIMIT);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == Limit);

endmodule

// File: rtl/dcpu_mem_arbiter.sv
// Two-port arbiter (CPU, DMA) for the single dcpu memory port with starvation
// promotion and bounded locked DMA bursts. Define DCPU_ARB_RR_EN for round-robin.
module dcpu_mem_arbiter
  import dcpu_bus_pkg::*;
#(
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 16,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cpu_req,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_dat,
  input  logic          i_cpu_rw,
  output logic          o_cpu_gnt,
  output logic          o_cpu_stall,
  input  logic          i_dma_req,
  input  logic          i_dma_lock,
  input  logic [AW-1:0] i_dma_addr,
  input  logic [DW-1:0] i_dma_dat,
  input  logic          i_dma_rw,
  output logic          o_dma_gnt,
  output logic [DW-1:0] o_rd_dat,
  output logic          o_mem_en,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_dat,
  input  logic [DW-1:0] i_mem_dat,
  output logic          o_mem_rw
);

  // burst_cnt holds grants already taken in the burst, so the grant made while
  // it equals BurstLast is the MAX_BURST-th and closes the burst.
  localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);

  arb_state_e state_q, state_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       post_burst_q, post_burst_d;
  logic       cpu_gnt, dma_gnt;
  logic       dma_pri;
  logic       starve_hit;

`ifdef DCPU_ARB_RR_EN
  logic last_owner_q;
`endif

  dcpu_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (i_clk),
    .reset (i_reset),
    .inc   (i_dma_req & ~dma_gnt),
    .clr   (dma_gnt | ~i_dma_req),
    .hit   (starve_hit)
  );

  always_comb begin
`ifdef DCPU_ARB_RR_EN
    dma_pri = (last_owner_q == PORT_CPU) | starve_hit;
`else
    dma_pri = starve_hit;
`endif
  end

  always_comb begin
    cpu_gnt      = 1'b0;
    dma_gnt      = 1'b0;
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    post_burst_d = 1'b0;
    if (!i_reset) begin
      unique case (state_q)
        S_ARB: begin
          // The cycle after a burst the CPU wins outright if it asks.
          if (i_dma_req && (!i_cpu_req || (dma_pri && !post_burst_q))) begin
            dma_gnt = 1'b1;
          end else if (i_cpu_req) begin
            cpu_gnt = 1'b1;
          end
          if (dma_gnt && i_dma_lock) begin
            if (MAX_BURST == 1) begin
              post_burst_d = 1'b1;
            end else begin
              state_d     = S_LOCK;
              burst_cnt_d = 8'd1;
            end
          end
        end
        S_LOCK: begin
          dma_gnt = i_dma_req;
          if (dma_gnt) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
          if (!i_dma_lock || !i_dma_req || (burst_cnt_q == BurstLast)) begin
            state_d      = S_ARB;
            burst_cnt_d  = '0;
            post_burst_d = 1'b1;
          end
        end
        default: state_d = S_ARB;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_ARB;
      burst_cnt_q  <= '0;
      post_burst_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      post_burst_q <= post_burst_d;
    end
  end

`ifdef DCPU_ARB_RR_EN
  // Reset value makes the CPU the first winner of a tie.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last_owner_q <= PORT_DMA;
    end else if (cpu_gnt) begin
      last_owner_q <= PORT_CPU;
    end else if (dma_gnt) begin
      last_owner_q <= PORT_DMA;
    end
  end
`endif

  always_comb begin
    o_mem_en   = 1'b0;
    o_mem_addr = '0;
    o_mem_dat  = '0;
    o_mem_rw   = RW_READ;
    if (cpu_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_cpu_addr;
      o_mem_dat  = i_cpu_dat;
      o_mem_rw   = i_cpu_rw;
    end else if (dma_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_dma_addr;
      o_mem_dat  = i_dma_dat;
      o_mem_rw   = i_dma_rw;
    end
  end

  assign o_cpu_gnt   = cpu_gnt;
  assign o_dma_gnt   = dma_gnt;
  assign o_cpu_stall = i_cpu_req & ~cpu_gnt & ~i_reset;
  assign o_rd_dat    = i_mem_dat;

endmodule

// File: tb/tb_dcpu_mem_arbiter.sv
// Directed bench for dcpu_mem_arbiter: vector table for reset, contention and
// bursts, plus hand sequences for the write path, mid-burst reset and round-robin.
module tb_dcpu_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_rw, dma_req, dma_lock, dma_rw;
  logic [15:0] cpu_addr, cpu_dat, dma_addr, dma_dat;
  logic        cpu_gnt, cpu_stall, dma_gnt, mem_en, mem_rw;
  logic [15:0] rd_dat, mem_addr, mem_wdat, mem_rdat;
  logic [15:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  dcpu_mem_arbiter dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_cpu_req   (cpu_req),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_dat   (cpu_dat),
    .i_cpu_rw    (cpu_rw),
    .o_cpu_gnt   (cpu_gnt),
    .o_cpu_stall (cpu_stall),
    .i_dma_req   (dma_req),
    .i_dma_lock  (dma_lock),
    .i_dma_addr  (dma_addr),
    .i_dma_dat   (dma_dat),
    .i_dma_rw    (dma_rw),
    .o_dma_gnt   (dma_gnt),
    .o_rd_dat    (rd_dat),
    .o_mem_en    (mem_en),
    .o_mem_addr  (mem_addr),
    .o_mem_dat   (mem_wdat),
    .i_mem_dat   (mem_rdat),
    .o_mem_rw    (mem_rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read RAM model.
  assign mem_rdat = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_en && !mem_rw) mem[mem_addr] <= mem_wdat;
  end

  typedef struct {
    logic rst, creq, dreq, lock;
    logic cg, dg;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic c, input logic d, input logic l,
                     input logic eg_c, input logic eg_d);
    vec_t v;
    v.rst = r; v.creq = c; v.dreq = d; v.lock = l; v.cg = eg_c; v.dg = eg_d;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic c, input logic d, input logic l);
    rst = r; cpu_req = c; dma_req = d; dma_lock = l;
  endtask

  initial begin
    logic [15:0] exp_addr;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    cpu_rw = 1'b1; dma_rw = 1'b1;
    cpu_addr = 16'h0100; dma_addr = 16'h0200;
    cpu_dat = 16'h0000; dma_dat = 16'h0000;

`ifndef DCPU_ARB_RR_EN
    // Reset with both requesting, then CPU alone.
    add(1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0);
    // Contention: four CPU grants, then DMA via starvation, twice.
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) add(0, 1, 1, 0, 1, 0);
      add(0, 1, 1, 0, 0, 1);
    end
    add(0, 0, 0, 0, 0, 0);
    // Locked burst: 8 DMA grants, one forced CPU grant, DMA re-locks.
    add(0, 0, 1, 1, 0, 1);
    for (int j = 0; j < 7; j++) add(0, 1, 1, 1, 0, 1);
    add(0, 1, 1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].creq, tbl[i].dreq, tbl[i].lock);
      @(negedge clk);
      exp_addr = tbl[i].cg ? 16'h0100 : (tbl[i].dg ? 16'h0200 : 16'h0000);
      check($sformatf("v%0d cpu_gnt", i), {15'b0, cpu_gnt}, {15'b0, tbl[i].cg});
      check($sformatf("v%0d dma_gnt", i), {15'b0, dma_gnt}, {15'b0, tbl[i].dg});
      check($sformatf("v%0d stall", i), {15'b0, cpu_stall},
            {15'b0, tbl[i].creq & ~tbl[i].cg & ~tbl[i].rst});
      check($sformatf("v%0d mem_en", i), {15'b0, mem_en}, {15'b0, tbl[i].cg | tbl[i].dg});
      check($sformatf("v%0d mem_addr", i), mem_addr, exp_addr);
      check($sformatf("v%0d mem_rw", i), {15'b0, mem_rw}, 16'h0001);
      next_cycle();
    end
`else
    next_cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check($sformatf("rr%0d cpu_gnt", j), {15'b0, cpu_gnt}, {15'b0, (j % 2) == 0});
      check($sformatf("rr%0d dma_gnt", j), {15'b0, dma_gnt}, {15'b0, (j % 2) == 1});
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
`endif

    // Write path: DMA writes, CPU reads it back.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    dma_rw = 1'b0; dma_addr = 16'h2000; dma_dat = 16'hBEEF;
    @(negedge clk);
    check("wr dma_gnt", {15'b0, dma_gnt}, 16'h0001);
    check("wr mem_rw", {15'b0, mem_rw}, 16'h0000);
    check("wr mem_dat", mem_wdat, 16'hBEEF);
    check("wr mem_addr", mem_addr, 16'h2000);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    dma_rw = 1'b1; dma_dat = 16'h0000; cpu_addr = 16'h2000;
    @(negedge clk);
    check("rd cpu_gnt", {15'b0, cpu_gnt}, 16'h0001);
    check("rd mem_rw", {15'b0, mem_rw}, 16'h0001);
    check("rd rd_dat", rd_dat, 16'hBEEF);
    next_cycle();

    // Reset on what would be the third burst grant.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    cpu_addr = 16'h0100; dma_addr = 16'h0200;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check($sformatf("mb grant%0d", j + 1), {15'b0, dma_gnt}, 16'h0001);
      next_cycle();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("mb rst dma_gnt", {15'b0, dma_gnt}, 16'h0000);
    check("mb rst stall", {15'b0, cpu_stall}, 16'h0000);
    next_cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("mb cpu_gnt", {15'b0, cpu_gnt}, 16'h0001);
    check("mb dma_gnt", {15'b0, dma_gnt}, 16'h0000);
    check("mb burst_cnt", {8'b0, dut.burst_cnt_q}, 16'h0000);
    check("mb mem_addr", mem_addr, 16'h0100);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
